// File: rtl/lmsm_mem_sequencer_pkg.sv
// Shared types and constants for the LM/SM memory sequencer.
// State encoding, opcode constants and default widths.
package lmsm_mem_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lmsm_state_t;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int DEF_NREG   = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit priority encoder for the LM/SM register list.
// R0 has the highest priority; o_valid flags a non-empty list.
module lmsm_prio_enc
    import lmsm_mem_sequencer_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    localparam int IW  = $clog2(NREG)
) (
    input  logic [NREG-1:0] i_list,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    always_comb begin
        o_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_valid = |i_list;

endmodule

// File: rtl/lmsm_mem_sequencer.sv
// MEM-stage sequencer for LM/SM: one access per set list bit,
// consecutive addresses, stalling the pipeline until finished.
module lmsm_mem_sequencer
    import lmsm_mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    localparam int IW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_list,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [IW-1:0]     rf_raddr,
    output logic [IW-1:0]     rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              busy,
    output logic              done
);

    lmsm_state_t       r_state;
    lmsm_state_t       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [NREG-1:0]   r_list;
    logic              r_dir;

    logic [IW-1:0]     w_idx;
    logic              w_valid;
    logic [NREG-1:0]   w_list_clr;

    lmsm_prio_enc #(
        .NREG    (NREG)
    ) u_prio (
        .i_list  (r_list),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_list_clr = r_list & ~(NREG'(1) << w_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_list  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_addr <= base_addr;
                r_list <= reg_list;
                r_dir  <= is_store;
            end else if (r_state == ST_RUN) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_list <= w_list_clr;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        rf_raddr  = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (reg_list != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                mem_addr = r_addr;
                if (r_dir) begin
                    rf_raddr  = w_idx;
                    mem_wdata = rf_rdata;
                    mem_we    = w_valid;
                end else begin
                    rf_waddr = w_idx;
                    rf_wdata = mem_rdata;
                    rf_we    = w_valid;
                end
                if (w_list_clr == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/lmsm_mem_sequencer.md
Name: lmsm_mem_sequencer

Overview:
- Initiator-side driver of the data memory port for multi-register LM/SM instructions in the pipelined processor.
- Sits in the MEM stage, between the register file and data_memory.
- Walks an 8-bit register list from R0 upward and issues one memory access per set bit at consecutive addresses.
- Holds the pipeline stalled until the list is exhausted.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, data word width
NREG, 8, architectural registers (register-list width)

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  one-cycle request to begin an LM/SM; sampled only in IDLE
is_store  in  1  1 = SM (reg->mem), 0 = LM (mem->reg)
base_addr  in  ADDR_W  first memory address (RA contents)
reg_list  in  NREG  bit i set = transfer Ri
mem_rdata  in  DATA_W  data_memory read data (combinational read)
rf_rdata  in  DATA_W  register file read data for rf_raddr (combinational)
mem_addr  out  ADDR_W  data_memory address
mem_wdata  out  DATA_W  data_memory write data
mem_we  out  1  data_memory write enable
rf_raddr  out  3  register file read index (SM)
rf_waddr  out  3  register file write index (LM)
rf_wdata  out  DATA_W  register file write data (LM)
rf_we  out  1  register file write enable
busy  out  1  sequencer active; used as pipeline stall
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE; internal addr_q, list_q, dir_q = 0.
  - All outputs 0 immediately, including mem_we and rf_we. No write can occur during reset.
- IDLE:
  - busy=0, done=0, all enables 0, mem_addr=0.
  - On a clk edge with start=1: latch addr_q=base_addr, list_q=reg_list, dir_q=is_store.
  - Next state: RUN if reg_list!=0, else DONE (zero-length op, no memory access).
- RUN:
  - busy=1.
  - idx = index of lowest set bit of list_q (R0 first).
  - mem_addr=addr_q.
  - SM: rf_raddr=idx, mem_wdata=rf_rdata, mem_we=1, rf_we=0.
  - LM: rf_waddr=idx, rf_wdata=mem_rdata, rf_we=1, mem_we=0.
  - Each clk edge: clear bit idx in list_q; addr_q=addr_q+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - When the cleared list becomes 0 -> DONE.
  - Exactly popcount(reg_list) RUN cycles.
- DONE:
  - done=1, busy=1, all enables 0.
  - Next edge -> IDLE.
- Latency: start edge to done pulse = popcount + 1 cycles. busy is asserted from the cycle after start through DONE inclusive.
- start while busy (RUN/DONE) is ignored; no queuing.
- Inputs base_addr, reg_list and is_store are don't-care after the start edge.
- Unused outputs hold 0 when not driven: mem_wdata=0 for LM, rf_wdata=0 for SM, and both indices=0 outside RUN.
- Register list containing the base register (LM overwriting RA): the address is already latched, so the sequence continues unaffected.
- Asynchronous reset mid-RUN: the access is aborted and any partial transfers already written remain. After release the block is in IDLE and requires a new start.
- All outputs are combinational from registered state plus mem_rdata/rf_rdata. No registered output delay.

Decomposition:
- Shared package:
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Opcode constants OP_LM=4'b0110, OP_SM=4'b0111.
  - NREG, ADDR_W, DATA_W defaults.
- Sub-module lmsm_prio_enc: NREG-bit list -> 3-bit lowest-set index plus valid. Purely combinational, instantiated once.

Test Plan:
- LM, base_addr=20, reg_list=8'b0000_0101, memory[20]=0x0001, memory[21]=0x0010 -> RUN cycle 1: rf_waddr=0, rf_wdata=0x0001, rf_we=1; cycle 2: rf_waddr=2, rf_wdata=0x0010; then done pulse; busy high 3 cycles; mem_we never 1.
- SM, base_addr=50, reg_list=8'b1000_0010, R1=0x00AA, R7=0x0055 -> mem[50]=0x00AA, mem[51]=0x0055; rf_we never 1; done at cycle 3.
- reg_list=0 with start=1 -> one DONE cycle (busy=1, done=1), zero memory or register writes, then IDLE.
- SM, base_addr=0xFFFF, reg_list=8'b0000_0011 -> writes at 0xFFFF then 0x0000 (wrap).
- start re-asserted during RUN of an 8-register LM -> ignored; exactly 8 transfers, single done pulse.
- reset driven low mid-RUN after 2 of 5 SM transfers -> mem_we=0 immediately, all outputs 0; exactly 2 words written; after release busy=0 and no further writes until a new start.
